// File: rtl/i2c_write_n.sv
// I2C master that sends one 7-bit write address followed by NBYTES data bytes.
// Open-drain SDA/SCL, quarter-period timebase with SCL stretching at the high phase.
`timescale 1ns/1ps
module i2c_write_n #(
  parameter int NBYTES       = 2,
  parameter int CLK_DIV      = 125,
  parameter int STOP_ON_NACK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            addr,
  input  logic [8*NBYTES-1:0]   data,
  output logic                  busy,
  output logic                  done,
  output logic [NBYTES:0]       nack,
  output logic                  abort,
  inout  wire                   sda,
  inout  wire                   scl
);

  localparam int TOT_W = 8 * (NBYTES + 1);
  localparam int QW    = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  state_t            state, state_nxt;
  logic [QW-1:0]     qcnt;
  logic [1:0]        qtr;
  logic [2:0]        bit_idx;
  logic [2:0]        byte_idx;
  logic [TOT_W-1:0]  shreg;
  logic              sda_lo, scl_lo;
  logic              sda_in, scl_in;
  logic              tick, hold, ack_abort, more_bytes;

  assign sda_in = sda;
  assign scl_in = scl;
  assign sda    = sda_lo ? 1'b0 : 1'bz;
  assign scl    = scl_lo ? 1'b0 : 1'bz;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  assign tick       = (qcnt == QW'(CLK_DIV - 1));
  // A slave holding SCL low freezes the quarter counter at the first cycle of the high phase.
  assign hold       = ((state == BIT) || (state == ACK)) && (qtr == 2'd2) && (qcnt == '0) && !scl_in;
  assign ack_abort  = (STOP_ON_NACK != 0) && sda_in;
  assign more_bytes = (byte_idx != 3'(NBYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sda_lo    = 1'b0;
    scl_lo    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = START;
      START: begin
        sda_lo = 1'b1;
        scl_lo = (qtr == 2'd1);
        if (tick && qtr == 2'd1) state_nxt = BIT;
      end
      BIT: begin
        sda_lo = !shreg[TOT_W-1];
        scl_lo = !qtr[1];
        if (tick && qtr == 2'd3) state_nxt = (bit_idx == 3'd7) ? ACK : BIT;
      end
      ACK: begin
        scl_lo = !qtr[1];
        if (tick && qtr == 2'd3) state_nxt = (more_bytes && !ack_abort) ? BIT : STOP;
      end
      STOP: begin
        scl_lo = (qtr == 2'd0);
        sda_lo = (qtr != 2'd2);
        if (tick && qtr == 2'd2) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt     <= '0;
      qtr      <= 2'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      nack     <= '0;
      abort    <= 1'b0;
    end else if (state == IDLE) begin
      qcnt <= '0;
      qtr  <= 2'd0;
      if (start) begin
        bit_idx  <= 3'd0;
        byte_idx <= 3'd0;
        nack     <= '0;
        abort    <= 1'b0;
      end
    end else if (state == DONE) begin
      qcnt <= '0;
      qtr  <= 2'd0;
    end else if (!hold) begin
      if (tick) begin
        qcnt <= '0;
        // Quarter index restarts on every state change; BIT->BIT wraps 3->0 naturally.
        qtr  <= (state_nxt == state) ? qtr + 2'd1 : 2'd0;
        if (state == BIT && qtr == 2'd3) bit_idx <= bit_idx + 3'd1;
        if (state == ACK && qtr == 2'd3) begin
          for (int i = 0; i <= NBYTES; i++)
            if (byte_idx == 3'(NBYTES - i)) nack[i] <= sda_in;
          byte_idx <= byte_idx + 3'd1;
          if (ack_abort) abort <= 1'b1;
        end
      end else begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end

  // Payload shift register: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start)
      shreg <= {addr, 1'b0, data};
    else if (state == BIT && tick && qtr == 2'd3)
      shreg <= shreg << 1;
  end

endmodule

// File: tb/tb_i2c_write_n.sv
// Bench for i2c_write_n: two instances (stop-on-NACK and send-all) each with a
// behavioural slave that records bytes, ACK/NACKs per byte and can stretch SCL.
`timescale 1ns/1ps
module tb_i2c_write_n;
  localparam int NB = 2;
  localparam int CD = 4;
  localparam int T_FULL = (2 + 36 * (NB + 1) + 3) * CD;  // 452
  localparam int T_ADDR = (2 + 36 + 3) * CD;             // 164
  // Slave holds SCL 37 cycles from the fall; 8 of them overlap the master's own low phase.
  localparam int T_STR  = T_FULL + 37 - 2 * CD;          // 481

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [6:0]  addr = 7'h0;
  logic [15:0] data = 16'h0;
  logic [1:0]  busy, done, abort;
  logic [2:0]  nack_a, nack_b;
  wire         sda_a, scl_a, sda_b, scl_b;
  logic [1:0]  s_sda_lo = 2'b00, s_scl_lo = 2'b00;

  pullup (sda_a);
  pullup (scl_a);
  pullup (sda_b);
  pullup (scl_b);
  assign sda_a = s_sda_lo[0] ? 1'b0 : 1'bz;
  assign scl_a = s_scl_lo[0] ? 1'b0 : 1'bz;
  assign sda_b = s_sda_lo[1] ? 1'b0 : 1'bz;
  assign scl_b = s_scl_lo[1] ? 1'b0 : 1'bz;

  i2c_write_n #(.NBYTES(NB), .CLK_DIV(CD), .STOP_ON_NACK(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr), .data(data),
    .busy(busy[0]), .done(done[0]), .nack(nack_a), .abort(abort[0]),
    .sda(sda_a), .scl(scl_a));

  i2c_write_n #(.NBYTES(NB), .CLK_DIV(CD), .STOP_ON_NACK(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr), .data(data),
    .busy(busy[1]), .done(done[1]), .nack(nack_b), .abort(abort[1]),
    .sda(sda_b), .scl(scl_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];
  logic [3:0] nack_cfg [2];
  int   bitc [2], bytec [2], hic [2], hi_bad [2], stops [2];
  int   stc = 0;
  logic [1:0] pc = 2'b11, ps = 2'b11;
  logic [7:0] sh [2];
  logic stretch_en = 1'b0;

  always @(negedge clk) begin
    if (stc > 0) begin
      stc = stc - 1;
      if (stc == 0) s_scl_lo[0] = 1'b0;
    end
  end

  // Slave model: samples the lines 1 ns after each falling clk edge.
  always @(negedge clk) begin : mon
    logic c, s;
    #1;
    for (int b = 0; b < 2; b++) begin
      c = (b == 0) ? scl_a : scl_b;
      s = (b == 0) ? sda_a : sda_b;
      if (pc[b] && c && ps[b] && !s) begin
        bitc[b] = 0; bytec[b] = 0; s_sda_lo[b] = 1'b0;
      end else if (pc[b] && c && !ps[b] && s) begin
        stops[b]++;
      end
      if (!pc[b] && c) begin
        hic[b] = 1;
        if (bitc[b] < 8) begin
          sh[b] = {sh[b][6:0], s};
          bitc[b]++;
          if (bitc[b] == 8) begin
            if (b == 0) obs_q0.push_back(sh[b]); else obs_q1.push_back(sh[b]);
          end
        end else if (bitc[b] == 8) begin
          bitc[b] = 9;
        end
      end else if (pc[b] && c) begin
        hic[b]++;
      end
      if (pc[b] && !c) begin
        if (bitc[b] > 0 && hic[b] != 2 * CD) hi_bad[b]++;
        if (bitc[b] == 8) s_sda_lo[b] = !nack_cfg[b][bytec[b]];
        else if (bitc[b] == 9) begin
          s_sda_lo[b] = 1'b0; bitc[b] = 0; bytec[b]++;
        end
        if (b == 0 && stretch_en && bytec[0] == 0 && bitc[0] == 3) begin
          s_scl_lo[0] = 1'b1; stc = 37; stretch_en = 1'b0;
        end
      end
      pc[b] = c;
      ps[b] = s;
    end
  end

  task automatic do_txn(input int b, input logic [6:0] a, input logic [15:0] d,
                        input logic [3:0] cfg, input int poke_at,
                        output int cyc, output bit to);
    nack_cfg[b] = cfg; hi_bad[b] = 0; stops[b] = 0;
    if (b == 0) obs_q0.delete(); else obs_q1.delete();
    @(negedge clk); addr = a; data = d; start[b] = 1'b1;
    @(negedge clk); start[b] = 1'b0; addr = 7'h0; data = 16'h0;
    cyc = 0;
    while (!done[b] && cyc < 5000) begin
      if (poke_at > 0 && cyc == poke_at) begin
        addr = 7'h55; data = 16'hFFFF; start[b] = 1'b1;
      end else start[b] = 1'b0;
      @(negedge clk); cyc++;
    end
    start[b] = 1'b0;
    to = !done[b];
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b expected 00", busy); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b expected 00", done); end
    checks++; if (nack_a !== 3'b000 || nack_b !== 3'b000) begin errors++; $display("FAIL reset_nack got %b/%b expected 000", nack_a, nack_b); end
    checks++; if (abort !== 2'b00) begin errors++; $display("FAIL reset_abort got %b expected 00", abort); end
    checks++; if (sda_a !== 1'b1 || scl_a !== 1'b1) begin errors++; $display("FAIL reset_lines got sda=%b scl=%b expected released", sda_a, scl_a); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal;
    int cyc; bit to; logic [7:0] e, o;
    exp_q0.push_back(8'h72); exp_q0.push_back(8'hA5); exp_q0.push_back(8'h5A);
    do_txn(0, 7'h39, 16'hA55A, 4'b0000, 0, cyc, to);
    checks++; if (to || cyc != T_FULL) begin errors++; $display("FAIL nominal_len got %0d expected %0d", cyc, T_FULL); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL nominal_busy_at_done got %b expected 0", busy[0]); end
    checks++; if (nack_a !== 3'b000) begin errors++; $display("FAIL nominal_nack got %b expected 000", nack_a); end
    checks++; if (abort[0] !== 1'b0) begin errors++; $display("FAIL nominal_abort got %b expected 0", abort[0]); end
    checks++; if (hi_bad[0] != 0) begin errors++; $display("FAIL nominal_scl_high got %0d bad pulses expected 0", hi_bad[0]); end
    checks++; if (stops[0] != 1) begin errors++; $display("FAIL nominal_stop got %0d expected 1", stops[0]); end
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++;
      if (obs_q0.size() == 0) begin errors++; $display("FAIL nominal_byte got none expected %h", e); end
      else begin o = obs_q0.pop_front(); if (o !== e) begin errors++; $display("FAIL nominal_byte got %h expected %h", o, e); end end
    end
    checks++; if (obs_q0.size() != 0) begin errors++; $display("FAIL nominal_extra got %0d bytes expected 0", obs_q0.size()); end
  endtask

  task automatic test_addr_nack;
    int cyc; bit to; logic [7:0] e, o;
    exp_q0.push_back(8'h72);
    do_txn(0, 7'h39, 16'hA55A, 4'b0001, 0, cyc, to);
    checks++; if (to || cyc != T_ADDR) begin errors++; $display("FAIL addrnack_len got %0d expected %0d", cyc, T_ADDR); end
    checks++; if (nack_a !== 3'b100) begin errors++; $display("FAIL addrnack_nack got %b expected 100", nack_a); end
    checks++; if (abort[0] !== 1'b1) begin errors++; $display("FAIL addrnack_abort got %b expected 1", abort[0]); end
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++;
      if (obs_q0.size() == 0) begin errors++; $display("FAIL addrnack_byte got none expected %h", e); end
      else begin o = obs_q0.pop_front(); if (o !== e) begin errors++; $display("FAIL addrnack_byte got %h expected %h", o, e); end end
    end
    checks++; if (obs_q0.size() != 0) begin errors++; $display("FAIL addrnack_databits got %0d bytes expected 0", obs_q0.size()); end
    repeat (20) @(negedge clk);
    checks++; if (nack_a !== 3'b100 || abort[0] !== 1'b1) begin errors++; $display("FAIL sticky_flags got %b/%b expected 100/1", nack_a, abort[0]); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [7:0] e, o;
    exp_q0.push_back(8'h72); exp_q0.push_back(8'hA5); exp_q0.push_back(8'h5A);
    obs_q0.delete(); nack_cfg[0] = 4'b0000;
    @(negedge clk); addr = 7'h39; data = 16'hA55A; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy_after_accept got %b expected 1", busy[0]); end
    checks++; if (nack_a !== 3'b000 || abort[0] !== 1'b0) begin errors++; $display("FAIL b2b_flags_cleared got %b/%b expected 000/0", nack_a, abort[0]); end
    cyc = 0;
    while (!done[0] && cyc < 5000) begin @(negedge clk); cyc++; end
    checks++; if (!done[0] || cyc != T_FULL) begin errors++; $display("FAIL b2b_len got %0d expected %0d", cyc, T_FULL); end
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++;
      if (obs_q0.size() == 0) begin errors++; $display("FAIL b2b_byte got none expected %h", e); end
      else begin o = obs_q0.pop_front(); if (o !== e) begin errors++; $display("FAIL b2b_byte got %h expected %h", o, e); end end
    end
    start[0] = 1'b1; addr = 7'h11;
    @(negedge clk); start[0] = 1'b0;
    checks++; if (busy[0] !== 1'b0 || sda_a !== 1'b1) begin errors++; $display("FAIL b2b_start_on_done got busy=%b sda=%b expected 0/1", busy[0], sda_a); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_data_nack_nostop;
    int cyc; bit to; logic [7:0] e, o;
    exp_q1.push_back(8'h72); exp_q1.push_back(8'hA5); exp_q1.push_back(8'h5A);
    do_txn(1, 7'h39, 16'hA55A, 4'b0010, 0, cyc, to);
    checks++; if (to || cyc != T_FULL) begin errors++; $display("FAIL datanack_len got %0d expected %0d", cyc, T_FULL); end
    checks++; if (nack_b !== 3'b010) begin errors++; $display("FAIL datanack_nack got %b expected 010", nack_b); end
    checks++; if (abort[1] !== 1'b0) begin errors++; $display("FAIL datanack_abort got %b expected 0", abort[1]); end
    while (exp_q1.size() > 0) begin
      e = exp_q1.pop_front(); checks++;
      if (obs_q1.size() == 0) begin errors++; $display("FAIL datanack_byte got none expected %h", e); end
      else begin o = obs_q1.pop_front(); if (o !== e) begin errors++; $display("FAIL datanack_byte got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_stretch;
    int cyc; bit to; logic [7:0] e, o;
    exp_q0.push_back(8'h72); exp_q0.push_back(8'hC3); exp_q0.push_back(8'h01);
    stretch_en = 1'b1;
    do_txn(0, 7'h39, 16'hC301, 4'b0000, 0, cyc, to);
    checks++; if (stretch_en !== 1'b0) begin errors++; $display("FAIL stretch_applied got %b expected 0", stretch_en); end
    checks++; if (to || cyc != T_STR) begin errors++; $display("FAIL stretch_len got %0d expected %0d", cyc, T_STR); end
    checks++; if (hi_bad[0] != 0) begin errors++; $display("FAIL stretch_scl_high got %0d bad pulses expected 0", hi_bad[0]); end
    checks++; if (nack_a !== 3'b000) begin errors++; $display("FAIL stretch_nack got %b expected 000", nack_a); end
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++;
      if (obs_q0.size() == 0) begin errors++; $display("FAIL stretch_byte got none expected %h", e); end
      else begin o = obs_q0.pop_front(); if (o !== e) begin errors++; $display("FAIL stretch_byte got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_busy_start;
    int cyc; bit to; logic [7:0] e, o;
    exp_q0.push_back(8'h72); exp_q0.push_back(8'h3C); exp_q0.push_back(8'h96);
    do_txn(0, 7'h39, 16'h3C96, 4'b0000, 100, cyc, to);
    checks++; if (to || cyc != T_FULL) begin errors++; $display("FAIL busystart_len got %0d expected %0d", cyc, T_FULL); end
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++;
      if (obs_q0.size() == 0) begin errors++; $display("FAIL busystart_byte got none expected %h", e); end
      else begin o = obs_q0.pop_front(); if (o !== e) begin errors++; $display("FAIL busystart_byte got %h expected %h", o, e); end end
    end
    checks++; if (obs_q0.size() != 0) begin errors++; $display("FAIL busystart_extra got %0d bytes expected 0", obs_q0.size()); end
  endtask

  task automatic test_reset_mid;
    int cyc; int w; bit to; logic [7:0] e, o;
    obs_q0.delete(); nack_cfg[0] = 4'b0000;
    @(negedge clk); addr = 7'h39; data = 16'hA55A; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    w = 0;
    while (obs_q0.size() == 0 && w < 2000) begin @(negedge clk); w++; end
    checks++; if (obs_q0.size() == 0) begin errors++; $display("FAIL rstmid_addr_seen got 0 bytes expected 1"); end
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got busy=%b done=%b expected 0/0", busy[0], done[0]); end
    checks++; if (sda_a !== 1'b1 || scl_a !== 1'b1) begin errors++; $display("FAIL rstmid_lines got sda=%b scl=%b expected released", sda_a, scl_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q0.push_back(8'h72); exp_q0.push_back(8'hA5); exp_q0.push_back(8'h5A);
    do_txn(0, 7'h39, 16'hA55A, 4'b0000, 0, cyc, to);
    checks++; if (to || cyc != T_FULL) begin errors++; $display("FAIL rstmid_next_len got %0d expected %0d", cyc, T_FULL); end
    checks++; if (nack_a !== 3'b000 || abort[0] !== 1'b0) begin errors++; $display("FAIL rstmid_next_flags got %b/%b expected 000/0", nack_a, abort[0]); end
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++;
      if (obs_q0.size() == 0) begin errors++; $display("FAIL rstmid_byte got none expected %h", e); end
      else begin o = obs_q0.pop_front(); if (o !== e) begin errors++; $display("FAIL rstmid_byte got %h expected %h", o, e); end end
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      nack_cfg[b] = 4'b0000; bitc[b] = 0; bytec[b] = 0; hic[b] = 0;
      hi_bad[b] = 0; stops[b] = 0; sh[b] = 8'h00;
    end
    test_reset();
    test_nominal();
    test_addr_nack();
    test_back_to_back();
    test_data_nack_nostop();
    test_stretch();
    test_busy_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
